ex14: RTL and testbench

Boolean-theorem demonstration block. It evaluates three combinational functions of inputs A, B, C. F1 and F2 are the two sides of De Morgan's theorem. F3 is the consensus-theorem expression. A clocked self-check section registers the results and flags any disagreement between the equivalent forms. It sits in the exercise/diagnostic area of the vending-machine design as a standalone leaf with no handshakes.

---
 rtl/ex14.sv | 36 +++
 tb/tb_ex14.sv | 116 +++++++++++
 2 files changed

// File: rtl/ex14.sv
// ex14: De Morgan and consensus theorem evaluator with a registered self-check
module ex14 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             F1,
    output logic             F2,
    output logic             F3,
    output logic [2:0]       F_q,
    output logic             theorem_err,
    output logic [CNT_W-1:0] eval_cnt
);
    logic r3;
    // NAND form and its De Morgan dual are kept as separate gate structures
    assign F1 = ~(A & B);
    assign F2 = ~A | ~B;
    // Full consensus expression drives the output; the reduced form is check-only
    assign F3 = (A & B) | (~A & C) | (B & C);
    assign r3 = (A & B) | (~A & C);
    // Sample the results, count evaluations and latch any theorem disagreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_q         <= 3'b000;
            theorem_err <= 1'b0;
            eval_cnt    <= '0;
        end else begin
            F_q         <= {F3, F2, F1};
            eval_cnt    <= eval_cnt + 1'b1;
            theorem_err <= theorem_err | (F1 != F2) | (F3 != r3);
        end
    end
endmodule

// File: tb/tb_ex14.sv
// tb_ex14: table-driven and scoreboard checks of the ex14 theorem block
module tb_ex14;
    logic clk = 0, run_clk = 0;
    logic rst_n, rst_n2, A, B, C;
    logic F1, F2, F3, err, F1b, F2b, F3b, err2;
    logic [2:0] F_q, F_q2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    int checks = 0, errors = 0;

    typedef struct {
        logic [2:0] abc;
        logic f1, f2, f3;
    } vec_t;
    vec_t tbl [8];
    logic [2:0] exp_q [$];
    logic [2:0] exp_fq;

    ex14 u_dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .F1(F1), .F2(F2), .F3(F3),
                .F_q(F_q), .theorem_err(err), .eval_cnt(cnt));
    ex14 #(.CNT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n2), .A(A), .B(B), .C(C), .F1(F1b), .F2(F2b),
                .F3(F3b), .F_q(F_q2), .theorem_err(err2), .eval_cnt(cnt2));

    initial begin
        wait (run_clk);
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_comb(input int i);
        chk("F1", 32'(F1), 32'(tbl[i].f1));
        chk("F2", 32'(F2), 32'(tbl[i].f2));
        chk("F3", 32'(F3), 32'(tbl[i].f3));
    endtask

    task automatic chk_rst();
        chk("rst_F_q", 32'(F_q), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(cnt), 0);
    endtask

    initial begin
        tbl[0] = '{3'b000, 1, 1, 0};
        tbl[1] = '{3'b001, 1, 1, 1};
        tbl[2] = '{3'b010, 1, 1, 0};
        tbl[3] = '{3'b011, 1, 1, 1};
        tbl[4] = '{3'b100, 1, 1, 0};
        tbl[5] = '{3'b101, 1, 1, 0};
        tbl[6] = '{3'b110, 0, 0, 1};
        tbl[7] = '{3'b111, 0, 0, 1};
        rst_n = 1; rst_n2 = 0;
        {A, B, C} = 3'b110; #1;
        chk_comb(6);
        {A, B, C} = 3'b000; #1;
        chk_comb(0);
        for (int i = 0; i < 8; i++) begin
            {A, B, C} = tbl[i].abc; #1;
            chk_comb(i);
        end
        rst_n = 0; #1;
        chk_rst();
        run_clk = 1;
        repeat (3) begin
            @(posedge clk); #1;
            chk_rst();
        end
        @(negedge clk);
        {A, B, C} = 3'b110;
        rst_n = 1;
        exp_q.push_back(3'b100);
        @(posedge clk); #1;
        exp_fq = exp_q.pop_front();
        chk("first_F_q", 32'(F_q), 32'(exp_fq));
        chk("first_cnt", 32'(cnt), 1);
        rst_n = 0; #1;
        rst_n = 1; rst_n2 = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            {A, B, C} = tbl[i % 8].abc;
            exp_q.push_back({tbl[i % 8].f3, tbl[i % 8].f2, tbl[i % 8].f1});
            @(posedge clk); #1;
            exp_fq = exp_q.pop_front();
            chk("sweep_F_q", 32'(F_q), 32'(exp_fq));
            chk("sweep_cnt", 32'(cnt), 32'(i + 1));
            chk("sweep_err", 32'(err), 0);
            if (i < 5) chk("wrap_cnt2", 32'(cnt2), 32'((i + 1) % 4));
        end
        chk("sweep_final_cnt", 32'(cnt), 16);
        chk("cnt2_err", 32'(err2), 0);
        #2 rst_n = 0; #1;
        chk_rst();
        {A, B, C} = 3'b101; #1;
        chk_comb(5);
        chk("midrst_F_q", 32'(F_q), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("rerelease_cnt", 32'(cnt), 1);
        chk("rerelease_F_q", 32'(F_q), 32'(3'b011));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
